// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-to-serial UART transmitter (8N1 by default).
// Takes one byte per new_data strobe while not busy and shifts it out
// LSB first on a registered tx pin: start bit, 8 data bits, stop bit.
// Each bit lasts CLK_PER_BIT clocks.
// Optional feature macro UART_TX_PARITY_EN: when defined, an even-parity
// bit is inserted after the data bits, which gives an 8E1 frame.
module uart_tx_serializer #(
  parameter int CLK_PER_BIT = 100,
  parameter int CTR_SIZE    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       busy,
  output logic       tx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  logic [2:0]          state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          data_q, data_d;
  logic                tx_q, tx_d;
  logic                block_q, block_d;
  logic                bit_done;

  assign bit_done = (ctr_q == CTR_LAST);
  assign block_d  = block;

  // Next-state, bit timing and output bit for the upcoming cycle
  always_comb begin
    state_d = state_q;
    ctr_d   = bit_done ? '0 : ctr_q + CTR_SIZE'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        ctr_d = '0;
        idx_d = '0;
        // block_q, not block: a block rising in this same cycle does not refuse the byte
        if (new_data && !block_q) begin
          data_d  = data;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_done) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
        idx_d   = '0;
      end
    endcase

    // tx is registered, so it is computed from the state being entered;
    // this makes tx fall on the edge that accepts the byte
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^data_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Control state; a reset abandons any frame at once and returns the line to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      block_q <= block_d;
    end
  end

  // Latched byte; only read outside IDLE, so it needs no reset
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign busy = (state_q != S_IDLE) | block_q;
  assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed vector bench for uart_tx_serializer
// with CLK_PER_BIT=4 and CTR_SIZE=2. It follows the UART_TX_PARITY_EN
// macro, so the same file covers both the 8N1 build and the 8E1 build.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       new_data;
  logic       block;
  logic       busy;
  logic       tx;

  int total  = 0;
  int passed = 0;

  // f = {stop, data[7:0], start}, written out by hand; par = hand-computed even parity
  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
    logic       par;
    string      name;
  } vec_t;

  vec_t tbl[9];

  uart_tx_serializer #(.CLK_PER_BIT(CPB), .CTR_SIZE(2)) dut (
    .clk(clk), .rst(rst), .data(data), .new_data(new_data),
    .block(block), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
  endtask

  function automatic logic exp_bit(input vec_t v, input int i);
`ifdef UART_TX_PARITY_EN
    if (i <= 8) return v.f[i];
    if (i == 9) return v.par;
    return v.f[9];
`else
    return v.f[i];
`endif
  endfunction

  // Sends one frame and checks tx/busy in every cycle of it, plus the first idle cycle.
  // Returns at the negedge of that first idle cycle.
  task automatic send_frame(input vec_t v, input bit self_strobe,
                            input int inj_cycle, input logic [7:0] inj_byte);
    if (self_strobe) begin
      @(negedge clk);
      data     = v.d;
      new_data = 1'b1;
    end
    @(posedge clk);
    #1;
    new_data = 1'b0;
    data     = ~v.d;
    for (int k = 1; k <= NB * CPB; k++) begin
      @(negedge clk);
      if (k == inj_cycle + 1) new_data = 1'b0;
      chk({v.name, " tx"}, tx, exp_bit(v, (k - 1) / CPB));
      chk({v.name, " busy"}, busy, 1'b1);
      if (k == inj_cycle) begin
        data     = inj_byte;
        new_data = 1'b1;
      end
    end
    @(negedge clk);
    chk({v.name, " idle tx"}, tx, 1'b1);
    chk({v.name, " idle busy"}, busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'h55, 10'b1010101010, 1'b0, "x55"};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b0, "x00"};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0, "xFF"};
    tbl[3] = '{8'h41, 10'b1010000010, 1'b0, "x41"};
    tbl[4] = '{8'h7E, 10'b1011111100, 1'b0, "x7E"};
    tbl[5] = '{8'h12, 10'b1000100100, 1'b0, "x12"};
    tbl[6] = '{8'hA3, 10'b1101000110, 1'b0, "xA3"};
    tbl[7] = '{8'h07, 10'b1000001110, 1'b1, "x07"};
    tbl[8] = '{8'h03, 10'b1000000110, 1'b0, "x03"};

    rst      = 1'b0;
    new_data = 1'b0;
    block    = 1'b0;
    data     = 8'h00;
    #12;
    chk("reset tx", tx, 1'b1);
    chk("reset busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset tx", tx, 1'b1);
    chk("post-reset busy", busy, 1'b0);

    // Table: each vector sent as a standalone frame
    for (int i = 0; i < 9; i++) send_frame(tbl[i], 1'b1, -1, 8'h00);

    // Back-to-back: 0x00, then 0xFF strobed in the first cycle with busy=0
    send_frame(tbl[1], 1'b1, -1, 8'h00);
    data     = 8'hFF;
    new_data = 1'b1;
    send_frame(tbl[2], 1'b0, -1, 8'h00);

    // 0xA3 strobed at cycle 10 of a 0x41 frame must be ignored
    send_frame(tbl[3], 1'b1, 10, 8'hA3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("after-ignored tx", tx, 1'b1);
      chk("after-ignored busy", busy, 1'b0);
    end

    // block held: a strobe is dropped and busy stays high
    @(negedge clk);
    block = 1'b1;
    @(negedge clk);
    chk("block busy", busy, 1'b1);
    data     = 8'h12;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("blocked tx", tx, 1'b1);
      chk("blocked busy", busy, 1'b1);
    end
    block = 1'b0;
    @(negedge clk);
    chk("unblock busy", busy, 1'b0);
    send_frame(tbl[5], 1'b1, -1, 8'h00);

    // Reset asserted during cycle 17 of a 0x00 frame (tx low in that cycle)
    @(negedge clk);
    data     = 8'h00;
    new_data = 1'b1;
    @(posedge clk);
    #1;
    new_data = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-rst tx", tx, 1'b0);
    chk("pre-rst busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("async rst tx", tx, 1'b1);
    chk("async rst busy", busy, 1'b0);
    @(negedge clk);
    chk("held rst tx", tx, 1'b1);
    rst = 1'b1;
    send_frame(tbl[4], 1'b1, -1, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
